// File: rtl/rvfpm_issue_queue_pkg.sv
// Shared types for the FPU issue queue: entry lifecycle states, the buffered
// payload record and the pointer-width helper.
package pa_rvfpm;

  localparam int IQ_DEPTH  = 4;
  localparam int IQ_ID_W   = 4;
  localparam int IQ_FLEN   = 32;
  localparam int IQ_NUM_RS = 3;

  typedef enum logic [1:0] {
    ENTRY_FREE      = 2'd0,
    ENTRY_PENDING   = 2'd1,
    ENTRY_COMMITTED = 2'd2,
    ENTRY_KILLED    = 2'd3
  } entry_state_e;

  // Payload widths are fixed by the package constants; the queue's width
  // parameters must match them.
  typedef struct packed {
    logic [31:0]                  instr;
    logic [IQ_ID_W-1:0]           id;
    logic [IQ_NUM_RS*IQ_FLEN-1:0] rs;
    logic [1:0]                   mode;
  } iq_entry_t;

  function automatic int iq_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int IQ_PTR_W = iq_ptr_w(IQ_DEPTH);

endpackage

// File: rtl/rvfpm_issue_queue.sv
// In-order issue/commit queue between the XIF issue/commit ports and the FPU
// pipeline: holds accepted instructions until committed (dispatch) or killed (drop).
module rvfpm_issue_queue
  import pa_rvfpm::*;
#(
  parameter int QUEUE_DEPTH = IQ_DEPTH,
  parameter int X_ID_WIDTH  = IQ_ID_W,
  parameter int FLEN        = IQ_FLEN,
  parameter int X_NUM_RS    = IQ_NUM_RS
) (
  input  logic                          ck,
  input  logic                          rst,
  input  logic                          issue_valid,
  output logic                          issue_ready,
  input  logic [31:0]                   issue_instr,
  input  logic [X_ID_WIDTH-1:0]         issue_id,
  input  logic [X_NUM_RS*FLEN-1:0]      issue_rs,
  input  logic [1:0]                    issue_mode,
  input  logic                          commit_valid,
  input  logic [X_ID_WIDTH-1:0]         commit_id,
  input  logic                          commit_kill,
  output logic                          disp_valid,
  input  logic                          disp_ready,
  output logic [31:0]                   disp_instr,
  output logic [X_ID_WIDTH-1:0]         disp_id,
  output logic [X_NUM_RS*FLEN-1:0]      disp_rs,
  output logic [1:0]                    disp_mode,
  output logic                          commit_miss,
  output logic [$clog2(QUEUE_DEPTH):0]  occupancy
);

  localparam int PTR_W = iq_ptr_w(QUEUE_DEPTH);
  localparam int OCC_W = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [OCC_W-1:0] FULL_COUNT = OCC_W'(QUEUE_DEPTH);

  entry_state_e            state_q [QUEUE_DEPTH];
  entry_state_e            state_d [QUEUE_DEPTH];
  iq_entry_t               entries_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0]        occ_q, occ_d;
  logic                    miss_q, miss_d;

  logic [QUEUE_DEPTH-1:0]  match;
  logic [QUEUE_DEPTH-1:0]  live_dup;
  logic                    issue_fire, incoming_match;
  logic                    disp_fire, drop, retire;
  entry_state_e            resolved_state;
  iq_entry_t               new_entry, head_entry;

  assign issue_ready    = (occ_q != FULL_COUNT);
  assign issue_fire     = issue_valid & issue_ready;
  assign incoming_match = commit_valid & issue_fire & (commit_id == issue_id);
  assign resolved_state = commit_kill ? ENTRY_KILLED : ENTRY_COMMITTED;
  assign new_entry      = '{instr: issue_instr, id: issue_id, rs: issue_rs, mode: issue_mode};

  // Only PENDING entries are commit targets; ids of live entries are unique.
  generate
    for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_match
      assign match[gi] = commit_valid && (state_q[gi] == ENTRY_PENDING) &&
                         (entries_q[gi].id == commit_id);
      assign live_dup[gi] = (state_q[gi] != ENTRY_FREE) && (entries_q[gi].id == issue_id) &&
                            !(retire && (head_q == PTR_W'(gi)));
    end
  endgenerate

  assign head_entry = entries_q[head_q];
  assign disp_valid = (state_q[head_q] == ENTRY_COMMITTED) && !rst;
  assign disp_fire  = disp_valid & disp_ready;
  assign drop       = (state_q[head_q] == ENTRY_KILLED);
  assign retire     = disp_fire | drop;

  assign disp_instr  = disp_valid ? head_entry.instr : '0;
  assign disp_id     = disp_valid ? head_entry.id    : '0;
  assign disp_rs     = disp_valid ? head_entry.rs    : '0;
  assign disp_mode   = disp_valid ? head_entry.mode  : '0;
  assign commit_miss = miss_q;
  assign occupancy   = occ_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    miss_d  = commit_valid && (match == '0) && !incoming_match;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (match[i]) state_d[i] = resolved_state;
    end
    // Head is never PENDING when retiring and tail slot is always FREE, so
    // these writes never collide with the commit updates above.
    if (retire) begin
      state_d[head_q] = ENTRY_FREE;
      head_d          = head_q + PTR_W'(1);
    end
    if (issue_fire) begin
      state_d[tail_q] = incoming_match ? resolved_state : ENTRY_PENDING;
      tail_d          = tail_q + PTR_W'(1);
    end
    case ({issue_fire, retire})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) state_q[i] <= ENTRY_FREE;
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      miss_q <= 1'b0;
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) state_q[i] <= state_d[i];
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      miss_q <= miss_d;
    end
  end

  always_ff @(posedge ck) begin
    if (issue_fire) entries_q[tail_q] <= new_entry;
  end

`ifndef SYNTHESIS
  always_ff @(posedge ck) begin
    if (!rst && issue_fire) begin
      assert (live_dup == '0)
        else $error("rvfpm_issue_queue: issue of id %0d already live", issue_id);
    end
  end
`endif

endmodule

// File: tb/tb_rvfpm_issue_queue.sv
// Directed table-driven bench for rvfpm_issue_queue plus hand-written
// sequences for latency and dispatch-stall stability.
module tb_rvfpm_issue_queue;

  localparam int DEPTH = 4;
  localparam int IDW   = 4;
  localparam int FLEN  = 32;
  localparam int NRS   = 3;
  localparam int OCCW  = $clog2(DEPTH) + 1;

  logic                  ck = 1'b0;
  logic                  rst;
  logic                  issue_valid, issue_ready;
  logic [31:0]           issue_instr;
  logic [IDW-1:0]        issue_id;
  logic [NRS*FLEN-1:0]   issue_rs;
  logic [1:0]            issue_mode;
  logic                  commit_valid, commit_kill;
  logic [IDW-1:0]        commit_id;
  logic                  disp_valid, disp_ready;
  logic [31:0]           disp_instr;
  logic [IDW-1:0]        disp_id;
  logic [NRS*FLEN-1:0]   disp_rs;
  logic [1:0]            disp_mode;
  logic                  commit_miss;
  logic [OCCW-1:0]       occupancy;

  rvfpm_issue_queue #(
    .QUEUE_DEPTH(DEPTH), .X_ID_WIDTH(IDW), .FLEN(FLEN), .X_NUM_RS(NRS)
  ) dut (
    .ck(ck), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr(issue_instr),
    .issue_id(issue_id), .issue_rs(issue_rs), .issue_mode(issue_mode),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_instr(disp_instr),
    .disp_id(disp_id), .disp_rs(disp_rs), .disp_mode(disp_mode),
    .commit_miss(commit_miss), .occupancy(occupancy)
  );

  always #5 ck = ~ck;

  typedef struct {
    bit             rst_i;
    bit             iv;
    logic [IDW-1:0] iid;
    bit             cv;
    logic [IDW-1:0] cid;
    bit             kill;
    bit             dr;
    bit             chk_disp;
    bit             e_ir;
    bit             e_dv;
    logic [IDW-1:0] e_id;
    logic [OCCW-1:0] e_occ;
    bit             e_miss;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t v(input bit r, input bit iv, input int iid, input bit cv,
                             input int cid, input bit kill, input bit dr, input bit cd,
                             input bit ir, input bit dv, input int did, input int occ,
                             input bit miss);
    vec_t t;
    t.rst_i = r;   t.iv = iv;   t.iid = IDW'(iid); t.cv = cv; t.cid = IDW'(cid);
    t.kill = kill; t.dr = dr;   t.chk_disp = cd;
    t.e_ir = ir;   t.e_dv = dv; t.e_id = IDW'(did); t.e_occ = OCCW'(occ); t.e_miss = miss;
    return t;
  endfunction

  // Payload is a fixed function of the id so each entry is distinguishable.
  function automatic logic [31:0] pay_instr(input logic [IDW-1:0] id);
    return 32'h0020_F050 | {28'h0, id};
  endfunction
  function automatic logic [NRS*FLEN-1:0] pay_rs(input logic [IDW-1:0] id);
    return {28'h0, id, 32'h4000_0000, 32'h3F80_0000};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    rst = 1'b0; issue_valid = 1'b0; issue_id = '0; issue_instr = '0; issue_rs = '0;
    issue_mode = '0; commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0;
  endtask

  task automatic drive_issue(input logic [IDW-1:0] id);
    issue_valid = 1'b1; issue_id = id; issue_instr = pay_instr(id);
    issue_rs = pay_rs(id); issue_mode = id[1:0];
  endtask

  task automatic chk_payload(input string tag, input bit dv, input logic [IDW-1:0] id);
    chk({tag, " disp_instr"}, 128'(disp_instr), dv ? 128'(pay_instr(id)) : 128'h0);
    chk({tag, " disp_rs"},    128'(disp_rs),    dv ? 128'(pay_rs(id))    : 128'h0);
    chk({tag, " disp_mode"},  128'(disp_mode),  dv ? 128'(id[1:0])       : 128'h0);
  endtask

  initial begin
    // rst iv id cv cid kill dr chk | ir dv did occ miss
    vecs.push_back(v(0,0, 0,0, 0,0,1,1, 1,0, 0,0,0));
    vecs.push_back(v(0,1, 3,1, 3,0,1,1, 1,0, 0,0,0)); // issue+commit same cycle
    vecs.push_back(v(0,0, 0,0, 0,0,1,1, 1,1, 3,1,0));
    vecs.push_back(v(0,0, 0,0, 0,0,1,1, 1,0, 0,0,0));
    vecs.push_back(v(0,1, 1,0, 0,0,1,1, 1,0, 0,0,0)); // fill to full
    vecs.push_back(v(0,1, 2,0, 0,0,1,1, 1,0, 0,1,0));
    vecs.push_back(v(0,1, 3,0, 0,0,1,1, 1,0, 0,2,0));
    vecs.push_back(v(0,1, 4,0, 0,0,1,1, 1,0, 0,3,0));
    vecs.push_back(v(0,1, 5,0, 0,0,1,1, 0,0, 0,4,0)); // held off
    vecs.push_back(v(0,1, 5,1, 1,0,1,1, 0,0, 0,4,0));
    vecs.push_back(v(0,0, 0,0, 0,0,1,1, 0,1, 1,4,0)); // no bypass while dispatching
    vecs.push_back(v(0,0, 0,1, 2,0,1,1, 1,0, 0,3,0));
    vecs.push_back(v(0,0, 0,1, 3,0,1,1, 1,1, 2,3,0));
    vecs.push_back(v(0,0, 0,1, 4,1,1,1, 1,1, 3,2,0));
    vecs.push_back(v(0,0, 0,0, 0,0,1,1, 1,0, 0,1,0)); // killed head dropped
    vecs.push_back(v(0,0, 0,0, 0,0,1,1, 1,0, 0,0,0));
    vecs.push_back(v(0,1, 5,0, 0,0,1,1, 1,0, 0,0,0)); // out-of-order commit
    vecs.push_back(v(0,1, 6,0, 0,0,1,1, 1,0, 0,1,0));
    vecs.push_back(v(0,0, 0,1, 6,0,1,1, 1,0, 0,2,0));
    vecs.push_back(v(0,0, 0,1, 5,0,1,1, 1,0, 0,2,0));
    vecs.push_back(v(0,0, 0,0, 0,0,1,1, 1,1, 5,2,0));
    vecs.push_back(v(0,0, 0,0, 0,0,1,1, 1,1, 6,1,0));
    vecs.push_back(v(0,0, 0,0, 0,0,1,1, 1,0, 0,0,0));
    vecs.push_back(v(0,1, 7,0, 0,0,1,1, 1,0, 0,0,0)); // kill then commit
    vecs.push_back(v(0,1, 8,0, 0,0,1,1, 1,0, 0,1,0));
    vecs.push_back(v(0,0, 0,1, 7,1,1,1, 1,0, 0,2,0));
    vecs.push_back(v(0,0, 0,1, 8,0,1,1, 1,0, 0,2,0));
    vecs.push_back(v(0,0, 0,0, 0,0,1,1, 1,1, 8,1,0));
    vecs.push_back(v(0,0, 0,0, 0,0,1,1, 1,0, 0,0,0));
    vecs.push_back(v(0,0, 0,1, 9,0,1,1, 1,0, 0,0,0)); // commit miss on empty queue
    vecs.push_back(v(0,0, 0,0, 0,0,1,1, 1,0, 0,0,1));
    vecs.push_back(v(0,0, 0,0, 0,0,1,1, 1,0, 0,0,0));
    vecs.push_back(v(0,1,10,1,10,0,0,1, 1,0, 0,0,0)); // fill with committed head stalled
    vecs.push_back(v(0,1,11,0, 0,0,0,1, 1,1,10,1,0));
    vecs.push_back(v(0,1,12,0, 0,0,0,1, 1,1,10,2,0));
    vecs.push_back(v(1,0, 0,0, 0,0,1,0, 1,0, 0,3,0)); // mid-operation reset
    vecs.push_back(v(0,0, 0,0, 0,0,1,1, 1,0, 0,0,0));
    vecs.push_back(v(0,1,13,1,13,0,0,1, 1,0, 0,0,0));
    vecs.push_back(v(0,0, 0,0, 0,0,0,1, 1,1,13,1,0));
    vecs.push_back(v(0,0, 0,0, 0,0,1,1, 1,1,13,1,0));
    vecs.push_back(v(0,0, 0,0, 0,0,1,1, 1,0, 0,0,0));

    drive_idle();
    disp_ready = 1'b0;
    rst = 1'b1;
    @(negedge ck); #1;
    chk("reset occupancy", 128'(occupancy), 128'h0);
    chk("reset issue_ready", 128'(issue_ready), 128'h1);
    chk("reset disp_valid", 128'(disp_valid), 128'h0);
    @(negedge ck); #1;
    chk("reset commit_miss", 128'(commit_miss), 128'h0);
    chk_payload("reset", 1'b0, '0);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t r;
      string tag;
      r = vecs[i];
      @(negedge ck);
      drive_idle();
      rst = r.rst_i;
      if (r.iv) drive_issue(r.iid);
      commit_valid = r.cv; commit_id = r.cid; commit_kill = r.kill;
      disp_ready = r.dr;
      #1;
      tag = $sformatf("row%0d", i);
      chk({tag, " issue_ready"}, 128'(issue_ready), 128'(r.e_ir));
      chk({tag, " occupancy"},   128'(occupancy),   128'(r.e_occ));
      chk({tag, " commit_miss"}, 128'(commit_miss), 128'(r.e_miss));
      if (r.chk_disp) begin
        chk({tag, " disp_valid"}, 128'(disp_valid), 128'(r.e_dv));
        chk({tag, " disp_id"},    128'(disp_id),    r.e_dv ? 128'(r.e_id) : 128'h0);
        chk_payload(tag, r.e_dv, r.e_id);
      end
      $display("row %0d rst=%0b iv=%0b id=%0d cv=%0b cid=%0d kill=%0b | ir=%0b dv=%0b did=%0d occ=%0d miss=%0b",
               i, r.rst_i, r.iv, r.iid, r.cv, r.cid, r.kill,
               issue_ready, disp_valid, disp_id, occupancy, commit_miss);
    end

    // Issue+commit with the pipeline stalled: disp_valid within one cycle,
    // payload stable until accepted.
    @(negedge ck);
    drive_idle();
    disp_ready = 1'b0;
    drive_issue(4'd14);
    commit_valid = 1'b1; commit_id = 4'd14;
    @(negedge ck);
    drive_idle();
    begin
      int waited = 0;
      #1;
      while (!disp_valid && waited < 8) begin
        @(negedge ck); #1;
        waited++;
      end
      chk("stall latency cycles", 128'(waited), 128'h0);
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d disp_valid", k), 128'(disp_valid), 128'h1);
      chk($sformatf("stall%0d disp_id", k), 128'(disp_id), 128'd14);
      chk_payload($sformatf("stall%0d", k), 1'b1, 4'd14);
      $display("stall %0d dv=%0b did=%0d occ=%0d", k, disp_valid, disp_id, occupancy);
      @(negedge ck); #1;
    end
    disp_ready = 1'b1;
    @(negedge ck); #1;
    chk("stall release disp_valid", 128'(disp_valid), 128'h0);
    chk("stall release occupancy", 128'(occupancy), 128'h0);
    $display("release dv=%0b occ=%0d", disp_valid, occupancy);

    // Kill an entry in the same cycle it issues: dropped without dispatch.
    drive_issue(4'd15);
    commit_valid = 1'b1; commit_id = 4'd15; commit_kill = 1'b1;
    @(negedge ck);
    drive_idle();
    #1;
    chk("issue-kill disp_valid", 128'(disp_valid), 128'h0);
    chk("issue-kill occupancy", 128'(occupancy), 128'h1);
    @(negedge ck); #1;
    chk("issue-kill drop occupancy", 128'(occupancy), 128'h0);
    chk("issue-kill commit_miss", 128'(commit_miss), 128'h0);
    $display("issue-kill dv=%0b occ=%0d", disp_valid, occupancy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rvfpm_issue_queue.md
Name: rvfpm_issue_queue

Overview:
- In-order issue/commit scheduler between the CORE-V-XIF issue/commit interfaces and the FPU execution pipeline.
- Buffers accepted instructions with their operands until the core commits or kills them.
- Releases committed instructions to the pipeline in program order over a valid/ready dispatch handshake, and silently drops killed ones.
- Replaces the ad-hoc accept/commit sequencing around the FPU model with a cycle-accurate RTL queue.

Parameters:
- QUEUE_DEPTH, 4, number of entries (power of two, >=2)
- X_ID_WIDTH, 4, width of the XIF instruction id
- FLEN, 32, operand width
- X_NUM_RS, 3, number of source operands carried per entry

Ports:
- ck  in  1  clock
- rst  in  1  reset, synchronous, active-high
- issue_valid  in  1  offloaded instruction present (already accepted by predecoder)
- issue_ready  out  1  queue can take an entry this cycle
- issue_instr  in  32  instruction word
- issue_id  in  X_ID_WIDTH  instruction id
- issue_rs  in  X_NUM_RS*FLEN  operands; rs[0] in the LSBs
- issue_mode  in  2  privilege mode
- commit_valid  in  1  commit/kill strobe
- commit_id  in  X_ID_WIDTH  id being committed/killed
- commit_kill  in  1  1 = kill, 0 = commit
- disp_valid  out  1  head entry ready to execute
- disp_ready  in  1  pipeline accepts head
- disp_instr  out  32  head instruction
- disp_id  out  X_ID_WIDTH  head id
- disp_rs  out  X_NUM_RS*FLEN  head operands
- disp_mode  out  2  head mode
- commit_miss  out  1  one-cycle pulse: commit_id matched no live entry
- occupancy  out  $clog2(QUEUE_DEPTH)+1  live entry count

Behaviour:
- Storage: circular buffer with head/tail pointers of $clog2(QUEUE_DEPTH) bits that wrap modulo QUEUE_DEPTH.
- Entry state (ENTRY_FREE, ENTRY_PENDING, ENTRY_COMMITTED, ENTRY_KILLED) is held in a QUEUE_DEPTH-entry state array.
- Reset: all entries FREE; head=tail=0; occupancy=0; commit_miss=0.
  - disp_* payload outputs read 0 while disp_valid=0.
  - rst asserted mid-operation discards every entry, committed or not, on that edge; no dispatch occurs in that cycle.
- issue_ready = (occupancy != QUEUE_DEPTH). It is combinational, with no bypass: a full queue rejects issue even if a dispatch fires in the same cycle.
- Issue fire = issue_valid & issue_ready. The entry is written at tail as PENDING and tail increments.
- Commit (commit_valid): the id is compared against all PENDING entries.
  - Match: the entry becomes COMMITTED (commit_kill=0) or KILLED (commit_kill=1).
  - If commit_id equals issue_id of an issue firing in the same cycle, the commit applies to the incoming entry, which is written directly as COMMITTED/KILLED.
  - No match at all: commit_miss pulses on the next cycle; no state change.
- Ids of live entries are unique. A duplicate-id issue is a protocol violation, flagged by a simulation assertion.
- Dispatch:
  - disp_valid = head entry COMMITTED (combinational from registered state).
  - disp_* are driven from the head entry.
  - Fire = disp_valid & disp_ready: head entry becomes FREE and head increments.
  - disp_* hold stable while disp_valid=1 and disp_ready=0.
- Drop: a KILLED head entry is freed and head increments in one cycle, with disp_valid=0. At most one head retirement (drop or dispatch) occurs per cycle.
- Latency: issue+commit in cycle N gives disp_valid=1 in cycle N+1. Commit at N of an already-queued head also gives disp_valid at N+1.
- Occupancy: +1 on issue fire, -1 on head retirement, unchanged when both occur.
- Ordering: strictly in-order. A committed entry behind a PENDING head waits.

Decomposition:
- pa_rvfpm holds:
  - the entry-state enum (ENTRY_FREE/PENDING/COMMITTED/KILLED);
  - the packed struct iq_entry_t {instr, id, rs, mode};
  - the QUEUE_DEPTH-derived pointer width.
- No sub-module. The id-match comparator is a generate loop in the block.

Test Plan:
- Issue id=3, instr=0x0020F053, rs[0]=0x3F800000, rs[1]=0x40000000 with commit_valid id=3 kill=0 in the same cycle; disp_ready=1 -> next cycle disp_valid=1, disp_id=3, disp_rs matches; occupancy returns to 0 one cycle after.
- Issue ids 1,2,3,4 with no commit (QUEUE_DEPTH=4) -> issue_ready=0 and occupancy=4; issue id 5 is held off. Commit id 1 -> dispatch fires, then issue_ready=1 again.
- Issue ids 5,6; commit 6 first -> disp_valid stays 0. Commit 5 -> disp_id=5, then disp_id=6 on consecutive cycles.
- Issue ids 7,8; kill 7, commit 8 -> 7 dropped with no disp_valid; next cycle disp_id=8.
- Commit id 9 with queue empty -> commit_miss=1 for one cycle, occupancy=0, no dispatch.
- Fill to 3 entries with head COMMITTED and disp_ready=0; assert rst for one cycle -> occupancy=0, disp_valid=0, issue_ready=1. Issue after reset writes to slot 0.
